// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
// Groups the core data-bus signals and the transmitter handshake signals shared
// between the core, the uart_tx_scheduler and the uart_tx_8n1 transmitter.
//
// Signals
//   bus_addr  [31:0]  core data address
//   bus_we            core store strobe, one write per cycle it is high
//   bus_wdata [31:0]  core store data
//   bus_rdata [31:0]  scheduler status read data (combinational)
//   tx_byte   [7:0]   byte presented to the transmitter
//   tx_send           one-cycle send pulse to the transmitter
//   tx_done           transmitter idle level (1 = ready)
//
// Modports
//   master : the surrounding system (core bus + transmitter)
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_done;

  modport master (
    output bus_addr, bus_we, bus_wdata, tx_done,
    input  bus_rdata, tx_byte, tx_send
  );

  modport slave (
    input  bus_addr, bus_we, bus_wdata, tx_done,
    output bus_rdata, tx_byte, tx_send
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one uart_tx_8n1 transmitter between a boot banner ROM and core MMIO
// stores. Core bytes written to TXDATA_ADDR are buffered in a FIFO; the banner
// (when enabled at reset) goes out first and has absolute priority until it
// ends. The send/done handshake guarantees each byte is sent exactly once.
//
// Ports
//   clk        in   rising-edge clock (transmitter clock domain)
//   rst        in   synchronous active-low reset (0 = reset)
//   banner_en  in   sampled in reset: 1 = send banner before FIFO traffic
//   bus        if   slave side of uart_tx_scheduler_if (bus + tx handshake)
//   irq_empty  out  FIFO empty, FSM idle and no banner pending
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          BANNER_LEN   = 16,
  parameter logic [31:0] TXDATA_ADDR  = 32'h0000_1000,
  parameter logic [31:0] STATUS_ADDR  = 32'h0000_1004,
  parameter int          BUSY_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  banner_en,
  uart_tx_scheduler_if.slave    bus,
  output logic                  irq_empty
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int IW = $clog2(BANNER_LEN + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [7:0] BANNER_ROM [16] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
    8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A, 8'h0D, 8'h00
  };

  typedef enum logic [1:0] {
    BANNER,
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            bannerActive_q, bannerActive_d;
  logic [IW-1:0]   bannerIdx_q, bannerIdx_d;
  logic [TW-1:0]   busyCnt_q, busyCnt_d;
  logic [7:0]      txByte_q, txByte_d;
  logic            txSend_q, txSend_d;
  logic [7:0]      fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic [7:0]      romByte;
  logic            bannerEnd;
  logic            sendBanner;
  logic            sendFifo;
  logic            fifoEmpty;
  logic            fifoFull;
  logic            pushReq;
  logic            pushOk;
  logic            dropPush;
  logic            clearOverflow;
  logic [31:0]     statusWord;
  logic            unusedWdata;

  // Banner ROM lookup. Any index at or beyond BANNER_LEN reads as NUL, so a
  // single "byte is zero" test covers both the terminator and the length limit.
  always_comb begin
    romByte = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (k < BANNER_LEN && bannerIdx_q == IW'(k)) begin
        romByte = BANNER_ROM[4'(k)];
      end
    end
  end

  assign bannerEnd = (romByte == 8'h00);
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CW'(FIFO_DEPTH));

  // FSM output decode: decides whether this cycle launches a banner byte or a
  // FIFO byte, and maintains the WAIT_BUSY timeout counter, which restarts
  // from zero on every send so each wait gets the full budget.
  always_comb begin
    sendBanner = 1'b0;
    sendFifo   = 1'b0;
    busyCnt_d  = busyCnt_q;
    case (state_q)
      BANNER:    sendBanner = bus.tx_done && !bannerEnd;
      IDLE:      sendFifo   = bus.tx_done && !fifoEmpty;
      WAIT_BUSY: busyCnt_d  = busyCnt_q + TW'(1);
      default:   ;
    endcase
    if (sendBanner || sendFifo) begin
      busyCnt_d = '0;
    end
  end

  // FSM next-state logic. WAIT_BUSY waits for the transmitter to acknowledge
  // the send by dropping tx_done, but gives up after BUSY_TIMEOUT cycles so a
  // transmitter that never drops tx_done cannot hang the scheduler.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BANNER: begin
        if (bannerEnd) begin
          state_d = IDLE;
        end else if (bus.tx_done) begin
          state_d = WAIT_BUSY;
        end
      end
      IDLE: begin
        if (sendFifo) begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!bus.tx_done || busyCnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          state_d = bannerActive_q ? BANNER : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transmit-side registers: the byte is held until the next send, the pulse
  // lasts exactly one cycle, and the banner retires permanently once it ends.
  always_comb begin
    txSend_d       = sendBanner || sendFifo;
    txByte_d       = txByte_q;
    bannerIdx_d    = bannerIdx_q;
    bannerActive_d = bannerActive_q;
    if (sendBanner) begin
      txByte_d    = romByte;
      bannerIdx_d = bannerIdx_q + IW'(1);
    end else if (sendFifo) begin
      txByte_d = fifoMem_q[rdPtr_q];
    end
    if (state_q == BANNER && bannerEnd) begin
      bannerActive_d = 1'b0;
    end
  end

  // Core FIFO bookkeeping. A push into a full FIFO still succeeds when a pop
  // happens in the same cycle; otherwise it is dropped and overflow is set.
  // A drop wins over a coincident overflow clear.
  always_comb begin
    pushReq       = bus.bus_we && (bus.bus_addr == TXDATA_ADDR);
    clearOverflow = bus.bus_we && (bus.bus_addr == STATUS_ADDR) && bus.bus_wdata[2];
    pushOk        = pushReq && (!fifoFull || sendFifo);
    dropPush      = pushReq && !pushOk;
    overflow_d    = dropPush || (overflow_q && !clearOverflow);
    wrPtr_d       = pushOk   ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d       = sendFifo ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d       = count_q;
    if (pushOk && !sendFifo) begin
      count_d = count_q + CW'(1);
    end else if (!pushOk && sendFifo) begin
      count_d = count_q - CW'(1);
    end
  end

  // Status word and read mux; the bus reads zero at every other address.
  always_comb begin
    statusWord = {16'h0000, 8'(count_q), 4'h0,
                  (state_q != IDLE), overflow_q, fifoEmpty, fifoFull};
    bus.bus_rdata = (bus.bus_addr == STATUS_ADDR) ? statusWord : 32'h0000_0000;
  end

  assign irq_empty   = fifoEmpty && (state_q == IDLE) && !bannerActive_q;
  assign bus.tx_byte = txByte_q;
  assign bus.tx_send = txSend_q;
  assign unusedWdata = ^bus.bus_wdata[31:8];

  // State register plus all control registers. Reset flushes the FIFO and
  // rearms the banner according to banner_en; a byte already handed to the
  // transmitter is left to finish on its own.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= banner_en ? BANNER : IDLE;
      bannerActive_q <= banner_en;
      bannerIdx_q    <= '0;
      busyCnt_q      <= '0;
      txByte_q       <= 8'h00;
      txSend_q       <= 1'b0;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bannerActive_q <= bannerActive_d;
      bannerIdx_q    <= bannerIdx_d;
      busyCnt_q      <= busyCnt_d;
      txByte_q       <= txByte_d;
      txSend_q       <= txSend_d;
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
    end
  end

  // FIFO storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoMem_q[wrPtr_q] <= bus.bus_wdata[7:0];
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Self-checking bench for uart_tx_scheduler. A transmitter model answers the
// send/done handshake and records every byte sent; expected byte streams are
// built from the banner text and a queue model of the core FIFO.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam logic [31:0] TXDATA   = 32'h0000_1000;
  localparam logic [31:0] STATUS   = 32'h0000_1004;
  localparam int          TIMEOUT  = 8;
  localparam int          TX_BUSY  = 10;
  localparam int          DEPTH    = 16;

  logic clk = 1'b0;
  logic rst;
  logic banner_en;
  logic irq_empty;

  uart_tx_scheduler_if ifc();

  uart_tx_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .banner_en (banner_en),
    .bus       (ifc),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  int          checks     = 0;
  int          failures   = 0;
  int          cyc        = 0;
  int          txMode     = 0;
  int          busyLeft   = 0;
  int          backToBack = 0;
  logic        prevSend   = 1'b0;
  byte unsigned sentQ[$];
  int          sentCyc[$];
  string       bannerText = "Hello, World!\n\r";

  // Cycle counter used to measure send latency and spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model and monitor: mode 0 goes busy TX_BUSY cycles per send,
  // mode 1 holds tx_done high, mode 2 holds it low. Every pulse is logged.
  always @(negedge clk) begin
    if (ifc.tx_send === 1'b1) begin
      sentQ.push_back(ifc.tx_byte);
      sentCyc.push_back(cyc);
      if (prevSend) backToBack++;
    end
    prevSend = (ifc.tx_send === 1'b1);
    case (txMode)
      1: ifc.tx_done = 1'b1;
      2: ifc.tx_done = 1'b0;
      default: begin
        if (ifc.tx_send === 1'b1) begin
          busyLeft    = TX_BUSY;
          ifc.tx_done = 1'b0;
        end else if (busyLeft > 0) begin
          busyLeft--;
          ifc.tx_done = (busyLeft == 0);
        end else begin
          ifc.tx_done = 1'b1;
        end
      end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we,
                               input logic [31:0] wdata);
    ifc.bus_addr  = addr;
    ifc.bus_we    = we;
    ifc.bus_wdata = wdata;
    @(negedge clk);
    ifc.bus_we    = 1'b0;
  endtask

  task automatic doReset(input logic be, input int cycles);
    rst       = 1'b0;
    banner_en = be;
    ifc.bus_we = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitSends(input string tag, input int n, input int budget);
    int k = 0;
    while (sentQ.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    checkOutput(tag, 32'(sentQ.size() >= n), 32'h1);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int k = 0;
    while (irq_empty !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 32'(irq_empty), 32'h1);
  endtask

  function automatic logic [31:0] sentAt(input int i);
    return (i < sentQ.size()) ? 32'(sentQ[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] statusOf(input int count, input bit full, input bit empty,
                                           input bit ovf, input bit busy);
    return (32'(count) << 8) | (32'(busy) << 3) | (32'(ovf) << 2) |
           (32'(empty) << 1) | 32'(full);
  endfunction

  initial begin
    byte unsigned expQ[$];
    byte unsigned modelQ[$];
    logic [31:0]  w;
    int           w0;

    ifc.bus_addr  = 32'h0;
    ifc.bus_we    = 1'b0;
    ifc.bus_wdata = 32'h0;
    @(negedge clk);

    // Reset with banner enabled; a core byte written mid-banner must follow it.
    doReset(1'b1, 3);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstTxSend", 32'(ifc.tx_send), 32'h0);
    checkOutput("rstTxByte", 32'(ifc.tx_byte), 32'h0);
    checkOutput("rstIrqBanner", 32'(irq_empty), 32'h0);
    ifc.bus_addr = STATUS;
    #1;
    checkOutput("rstStatusBanner", ifc.bus_rdata, statusOf(0, 0, 1, 0, 1));
    rst = 1'b1;
    sentQ.delete();
    sentCyc.delete();
    repeat (3) @(negedge clk);
    applyStimulus(TXDATA, 1'b1, ($urandom & 32'hFFFF_FF00) | 32'h5A);
    expQ.delete();
    for (int i = 0; i < bannerText.len(); i++) expQ.push_back(bannerText[i]);
    expQ.push_back(8'h5A);
    waitSends("bannerSendCount", expQ.size(), 800);
    for (int i = 0; i < expQ.size(); i++)
      checkOutput($sformatf("bannerByte%0d", i), sentAt(i), 32'(expQ[i]));
    waitIdle("bannerIdle", 100);
    ifc.bus_addr = STATUS;
    #1;
    checkOutput("bannerEndStatus", ifc.bus_rdata, statusOf(0, 0, 1, 0, 0));
    checkOutput("bannerTotal", 32'(sentQ.size()), 32'(expQ.size()));

    // No banner, transmitter always ready: write-to-send latency is two cycles.
    @(negedge clk);
    txMode = 1;
    doReset(1'b0, 2);
    repeat (5) @(negedge clk);
    checkOutput("idleIrq", 32'(irq_empty), 32'h1);
    sentQ.delete();
    sentCyc.delete();
    w0 = cyc;
    applyStimulus(TXDATA, 1'b1, ($urandom & 32'hFFFF_FF00) | 32'h41);
    repeat (5) @(negedge clk);
    checkOutput("latencyCount", 32'(sentQ.size()), 32'h1);
    checkOutput("latencyByte", sentAt(0), 32'h41);
    checkOutput("latencyCycles", (sentCyc.size() > 0) ? 32'(sentCyc[0] - w0) : 32'hFFFF, 32'h2);

    // tx_done stuck high: each wait times out, so sends are TIMEOUT+2 apart.
    expQ.delete();
    expQ.push_back(8'h41);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      expQ.push_back(w[7:0]);
      applyStimulus(TXDATA, 1'b1, w);
    end
    waitSends("stuckSendCount", 4, 200);
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("stuckByte%0d", i), sentAt(i), 32'(expQ[i]));
      checkOutput($sformatf("stuckGap%0d", i),
                  (sentCyc.size() > i) ? 32'(sentCyc[i] - sentCyc[i-1]) : 32'hFFFF,
                  32'(TIMEOUT + 2));
    end
    waitIdle("stuckIdle", 100);

    // Transmitter held busy: overfill the FIFO, check status and clearing.
    txMode = 2;
    repeat (2) @(negedge clk);
    modelQ.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = $urandom;
      if (modelQ.size() < DEPTH) modelQ.push_back(w[7:0]);
      applyStimulus(TXDATA, 1'b1, w);
    end
    ifc.bus_addr = STATUS;
    #1;
    checkOutput("fullStatus", ifc.bus_rdata, statusOf(DEPTH, 1, 0, 1, 0));
    ifc.bus_addr = TXDATA;
    #1;
    checkOutput("rdataOtherAddr", ifc.bus_rdata, 32'h0);
    applyStimulus(STATUS, 1'b1, 32'h0000_0004);
    ifc.bus_addr = STATUS;
    #1;
    checkOutput("ovfCleared", ifc.bus_rdata, statusOf(DEPTH, 1, 0, 0, 0));
    sentQ.delete();
    sentCyc.delete();
    txMode = 0;
    waitSends("drainSendCount", DEPTH, 600);
    for (int i = 0; i < DEPTH; i++)
      checkOutput($sformatf("drainByte%0d", i), sentAt(i), 32'(modelQ[i]));
    waitIdle("drainIdle", 100);
    checkOutput("drainTotal", 32'(sentQ.size()), 32'(DEPTH));

    // One-cycle reset with three bytes queued and a byte in flight.
    for (int i = 0; i < 4; i++) applyStimulus(TXDATA, 1'b1, $urandom);
    ifc.bus_addr = STATUS;
    #1;
    checkOutput("midQueued", ifc.bus_rdata, statusOf(3, 0, 0, 0, 1));
    @(negedge clk);
    doReset(1'b1, 1);
    sentQ.delete();
    sentCyc.delete();
    #1;
    checkOutput("midRstTxSend", 32'(ifc.tx_send), 32'h0);
    checkOutput("midRstStatus", ifc.bus_rdata, statusOf(0, 0, 1, 0, 1));
    waitSends("rebannerCount", bannerText.len(), 800);
    for (int i = 0; i < bannerText.len(); i++)
      checkOutput($sformatf("rebannerByte%0d", i), sentAt(i), 32'(bannerText[i]));
    waitIdle("rebannerIdle", 100);
    checkOutput("rebannerTotal", 32'(sentQ.size()), 32'(bannerText.len()));

    checkOutput("noBackToBackSend", 32'(backToBack), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
